core_avalon_master: RTL
=======================

Name: core_avalon_master

Overview:
- Load/store bridge between the RISC-V core's data-memory port and the Avalon-MM system's `mm_bridge_s` slave.
- Accepts one core request at a time and derives byte enables and write-lane replication.
- Drives a single-beat Avalon read or write, waits out `waitrequest` and `readdatavalid`, then aligns and extends load data.
- Returns a one-cycle response with an error code. No transaction is outstanding after the response.

Parameters:
- ADDR_W, 28, Avalon byte-address width; must match `mm_bridge_s_address`.
- TIMEOUT_CYCLES, 1023, bus-cycle budget per transaction before abort. Used only with the optional feature.

Ports:
- clk_clk  in  1  system clock
- reset_reset  in  1  synchronous reset, active-high
- req_valid  in  1  core request present
- req_ready  out  1  bridge idle, can accept
- req_we  in  1  1=store, 0=load
- req_addr  in  32  byte address
- req_size  in  2  0=byte, 1=half, 2=word, 3=illegal
- req_unsigned  in  1  load zero-extend (LBU/LHU)
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  one-cycle response strobe
- rsp_rdata  out  32  aligned and extended load data; 0 for stores and errors
- rsp_err  out  2  0=ok, 1=misaligned, 2=illegal size/address, 3=timeout
- avm_address  out  ADDR_W  word-aligned byte address
- avm_read  out  1  Avalon read
- avm_write  out  1  Avalon write
- avm_writedata  out  32  lane-replicated store data
- avm_byteenable  out  4  lane enables
- avm_burstcount  out  1  constant 1
- avm_debugaccess  out  1  constant 0
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  32  read data
- avm_readdatavalid  in  1  read data strobe

Behaviour:
- Reset values:
  - req_ready=0 during reset, 1 the cycle after.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - avm_read=0, avm_write=0, avm_address=0, avm_writedata=0, avm_byteenable=0.
  - State is IDLE.
- All outputs are registered. `req_ready` = (state==IDLE).
- FSM states:
  - IDLE → CMD on accept (`req_valid && req_ready`) when the request is legal. The request is latched.
  - IDLE → RESP on accept when the request is illegal. No bus cycle is issued.
  - CMD: hold `avm_read` or `avm_write` and all address/data/enable signals stable while `avm_waitrequest`=1.
    - If `waitrequest`=0 and the request is a write → RESP.
    - If `waitrequest`=0 and the request is a read → RDWAIT. `avm_read` drops the next cycle.
    - If `waitrequest`=0 and `readdatavalid`=1 in the same cycle → capture data, go to RESP.
  - RDWAIT: wait for `avm_readdatavalid`, capture `readdata`, → RESP.
  - RESP: `rsp_valid`=1 for exactly one cycle → IDLE.
- Legality checks:
  - Misaligned (err 1): half with addr[0]=1; word with addr[1:0]≠0.
  - Illegal (err 2): size=3, or `req_addr[31:ADDR_W]`≠0. Misaligned takes priority over illegal.
- Address: `avm_address = {req_addr[ADDR_W-1:2], 2'b00}`.
- Byte enables:
  - byte → `4'b0001 << addr[1:0]`
  - half → `4'b0011 << addr[1:0]`
  - word → `4'b1111`
- Write data replication:
  - byte → `{4{wdata[7:0]}}`
  - half → `{2{wdata[15:0]}}`
  - word → `wdata`
- Load path: shift = `readdata >> (8*addr[1:0])`; truncate to size; sign-extend unless `req_unsigned`. Word loads ignore `req_unsigned`.
- Latency with waitrequest=0 (accept = cycle 0):
  - Store: `avm_write` in cycle 1, `rsp_valid` in cycle 2.
  - Load: `avm_read` in cycle 1; `readdatavalid` in cycle k≥1; `rsp_valid` in cycle k+1.
  - Error: `rsp_valid` in cycle 1.
- `avm_readdatavalid` outside CMD/RDWAIT for a read is ignored. This covers stray beats after an abort or reset.
- Reset mid-transaction: the FSM returns to IDLE and the bus request drops in the cycle after reset. No response is generated.
- `req_valid` while `req_ready`=0 is ignored. The core holds the request until accepted.

Optional Feature:
- Macro: CORE_AVALON_MASTER_TIMEOUT_EN.
- When defined:
  - A counter of width `$clog2(TIMEOUT_CYCLES+1)` clears on accept and increments each cycle in CMD or RDWAIT.
  - When it reaches TIMEOUT_CYCLES, `avm_read`/`avm_write` are deasserted and the FSM goes to RESP with err 3 and rdata 0.
- When undefined: no counter; the bridge waits indefinitely, and err 3 is never produced.

Decomposition:
- Package `core_mem_pkg` holds:
  - size constants SZ_B, SZ_H, SZ_W
  - error-code constants ERR_NONE, ERR_MISALIGN, ERR_ILLEGAL, ERR_TIMEOUT
  - FSM state enum (IDLE, CMD, RDWAIT, RESP)
- One combinational sub-module, `mem_lane_align`, handles byteenable generation, write replication, legality check and load extract/extend. The top holds the FSM, registers and timeout counter.

Test Plan:
- SW 0x0000_0104 data 0xDEADBEEF, waitrequest=0 → `avm_write` cycle 1, address 0x0000104, byteenable 0xF, writedata 0xDEADBEEF; `rsp_valid` cycle 2 with err 0.
- SB addr 0x0000_0003 data 0x000000A5 → byteenable 0x8, writedata 0xA5A5A5A5.
- LH addr 0x0000_0012, readdata 0x8001_0000, `readdatavalid` 3 cycles after accept → `rsp_rdata` 0xFFFF8001.
  - Same with LHU → `rsp_rdata` 0x00008001.
  - `rsp_valid` one cycle after `readdatavalid`.
- LW with waitrequest held high 5 cycles → `avm_read`, address and byteenable stable for all 5 cycles; a single response follows.
- LW addr 0x0000_0002 → err 1 and SW addr 0x1000_0000 → err 2; both give `rsp_valid` at cycle 1 with no `avm_read`/`avm_write` ever asserted.
- With TIMEOUT_EN and TIMEOUT_CYCLES=8, LW and `readdatavalid` never asserted → err 3 after 8 bus cycles; a late `readdatavalid` is then ignored and the next request completes normally.

Source files
------------

// File: rtl/core_mem_pkg.sv
// rtl/core_mem_pkg.sv - shared constants and FSM state type for the core data-memory bridge
//
// Contents:
//   SZ_B / SZ_H / SZ_W       request size encodings (3 is illegal)
//   ERR_NONE .. ERR_TIMEOUT  response error codes
//   state_t                  bridge FSM states
package core_mem_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_MISALIGN = 2'd1;
    localparam logic [1:0] ERR_ILLEGAL  = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        RDWAIT,
        RESP
    } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane steering, legality check and load extract/extend
//
// Purely combinational.
// Request side (driven from the live core request):
//   i_addr, i_size, i_wdata  -> o_err, o_byteenable, o_wdata
// Load side (driven from the latched request):
//   i_ld_off, i_ld_size, i_ld_unsigned, i_rdata -> o_rdata
module mem_lane_align
    import core_mem_pkg::*;
#(
    parameter int ADDR_W = 28
) (
    input  logic [31:0] i_addr,
    input  logic [1:0]  i_size,
    input  logic [31:0] i_wdata,
    output logic [1:0]  o_err,
    output logic [3:0]  o_byteenable,
    output logic [31:0] o_wdata,
    input  logic [1:0]  i_ld_off,
    input  logic [1:0]  i_ld_size,
    input  logic        i_ld_unsigned,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_rdata
);

    logic [31:0] w_shifted;

    // Misalignment is checked first so it wins over the illegal-size/range code.
    // The shift form of the range check keeps it valid for any ADDR_W below 32.
    always_comb begin
        o_err = ERR_NONE;
        if ((i_size == SZ_H && i_addr[0]) || (i_size == SZ_W && i_addr[1:0] != 2'b00)) begin
            o_err = ERR_MISALIGN;
        end else if (i_size == 2'd3 || (i_addr >> ADDR_W) != 32'd0) begin
            o_err = ERR_ILLEGAL;
        end
    end

    always_comb begin
        o_byteenable = 4'b1111;
        o_wdata      = i_wdata;
        case (i_size)
            SZ_B: begin
                o_byteenable = 4'b0001 << i_addr[1:0];
                o_wdata      = {4{i_wdata[7:0]}};
            end
            SZ_H: begin
                o_byteenable = 4'b0011 << i_addr[1:0];
                o_wdata      = {2{i_wdata[15:0]}};
            end
            default: begin
                o_byteenable = 4'b1111;
                o_wdata      = i_wdata;
            end
        endcase
    end

    assign w_shifted = i_rdata >> {i_ld_off, 3'b000};

    always_comb begin
        o_rdata = i_rdata;
        case (i_ld_size)
            SZ_B:    o_rdata = {{24{!i_ld_unsigned && w_shifted[7]}}, w_shifted[7:0]};
            SZ_H:    o_rdata = {{16{!i_ld_unsigned && w_shifted[15]}}, w_shifted[15:0]};
            default: o_rdata = i_rdata;
        endcase
    end

endmodule

// File: rtl/core_avalon_master.sv
// rtl/core_avalon_master.sv - single-beat Avalon-MM master for the core load/store port
//
// Optional feature macro: CORE_AVALON_MASTER_TIMEOUT_EN (per-transaction bus-cycle watchdog).
// Ports:
//   clk_clk, reset_reset                 clock, synchronous active-high reset
//   req_valid/req_ready/req_we/req_addr/req_size/req_unsigned/req_wdata   core request
//   rsp_valid/rsp_rdata/rsp_err          one-cycle response
//   avm_*                                Avalon-MM master towards mm_bridge_s
module core_avalon_master
    import core_mem_pkg::*;
#(
    parameter int ADDR_W         = 28,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic [1:0]        rsp_err,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    output logic [3:0]        avm_byteenable,
    output logic              avm_burstcount,
    output logic              avm_debugaccess,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_readdatavalid
);

    state_t            r_state;
    state_t            w_state_next;
    logic              r_req_ready;
    logic              r_rsp_valid;
    logic [31:0]       r_rsp_rdata;
    logic [1:0]        r_rsp_err;
    logic [ADDR_W-1:0] r_avm_address;
    logic              r_avm_read;
    logic              r_avm_write;
    logic [31:0]       r_avm_writedata;
    logic [3:0]        r_avm_byteenable;
    logic              r_we;
    logic [1:0]        r_ld_off;
    logic [1:0]        r_size;
    logic              r_unsigned;

    logic              w_accept;
    logic              w_we_next;
    logic              w_rd_capture;
    logic              w_abort;
    logic              w_timeout;
    logic [1:0]        w_chk_err;
    logic [3:0]        w_byteenable;
    logic [31:0]       w_wdata;
    logic [31:0]       w_ld_data;

    mem_lane_align #(
        .ADDR_W (ADDR_W)
    ) u_align (
        .i_addr        (req_addr),
        .i_size        (req_size),
        .i_wdata       (req_wdata),
        .o_err         (w_chk_err),
        .o_byteenable  (w_byteenable),
        .o_wdata       (w_wdata),
        .i_ld_off      (r_ld_off),
        .i_ld_size     (r_size),
        .i_ld_unsigned (r_unsigned),
        .i_rdata       (avm_readdata),
        .o_rdata       (w_ld_data)
    );

    assign w_accept  = req_valid && r_req_ready;
    assign w_we_next = w_accept ? req_we : r_we;

    // Read data is only taken while this bridge owns a read; beats arriving in
    // IDLE/RESP (e.g. left over from an aborted or reset transaction) are dropped.
    assign w_rd_capture = !r_we && avm_readdatavalid &&
                          ((r_state == CMD && !avm_waitrequest) || r_state == RDWAIT);

`ifdef CORE_AVALON_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_cnt_inc = r_cnt + 1'b1;
    // Fires in the bus cycle that would bring the count to TIMEOUT_CYCLES.
    assign w_timeout = (r_state == CMD || r_state == RDWAIT) &&
                       (w_cnt_inc == CNT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
        end else if (r_state == CMD || r_state == RDWAIT) begin
            r_cnt <= w_cnt_inc;
        end
    end
`else
    logic w_unused_timeout;

    assign w_timeout        = 1'b0;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    // Completion takes priority over a timeout landing in the same cycle.
    always_comb begin
        w_state_next = r_state;
        w_abort      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = (w_chk_err == ERR_NONE) ? CMD : RESP;
                end
            end
            CMD: begin
                if (!avm_waitrequest && (r_we || avm_readdatavalid)) begin
                    w_state_next = RESP;
                end else if (w_timeout) begin
                    w_state_next = RESP;
                    w_abort      = 1'b1;
                end else if (!avm_waitrequest) begin
                    w_state_next = RDWAIT;
                end
            end
            RDWAIT: begin
                if (avm_readdatavalid) begin
                    w_state_next = RESP;
                end else if (w_timeout) begin
                    w_state_next = RESP;
                    w_abort      = 1'b1;
                end
            end
            RESP: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so that ready, the bus strobes
    // and the response strobe all line up with the state they describe.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_state          <= IDLE;
            r_req_ready      <= 1'b0;
            r_rsp_valid      <= 1'b0;
            r_rsp_rdata      <= '0;
            r_rsp_err        <= ERR_NONE;
            r_avm_address    <= '0;
            r_avm_read       <= 1'b0;
            r_avm_write      <= 1'b0;
            r_avm_writedata  <= '0;
            r_avm_byteenable <= '0;
            r_we             <= 1'b0;
            r_ld_off         <= '0;
            r_size           <= '0;
            r_unsigned       <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_req_ready <= (w_state_next == IDLE);
            r_rsp_valid <= (w_state_next == RESP);
            r_avm_read  <= (w_state_next == CMD) && !w_we_next;
            r_avm_write <= (w_state_next == CMD) && w_we_next;
            r_rsp_err   <= ERR_NONE;
            r_rsp_rdata <= '0;
            if (w_accept) begin
                r_we       <= req_we;
                r_ld_off   <= req_addr[1:0];
                r_size     <= req_size;
                r_unsigned <= req_unsigned;
                if (w_chk_err == ERR_NONE) begin
                    r_avm_address    <= {req_addr[ADDR_W-1:2], 2'b00};
                    r_avm_byteenable <= w_byteenable;
                    r_avm_writedata  <= w_wdata;
                end else begin
                    r_rsp_err <= w_chk_err;
                end
            end
            if (w_abort) begin
                r_rsp_err <= ERR_TIMEOUT;
            end
            if (w_rd_capture) begin
                r_rsp_rdata <= w_ld_data;
            end
        end
    end

    assign req_ready       = r_req_ready;
    assign rsp_valid       = r_rsp_valid;
    assign rsp_rdata       = r_rsp_rdata;
    assign rsp_err         = r_rsp_err;
    assign avm_address     = r_avm_address;
    assign avm_read        = r_avm_read;
    assign avm_write       = r_avm_write;
    assign avm_writedata   = r_avm_writedata;
    assign avm_byteenable  = r_avm_byteenable;
    assign avm_burstcount  = 1'b1;
    assign avm_debugaccess = 1'b0;

endmodule
